// File: rtl/int_div_pkg.sv
// Shared types and helpers for the sequential signed divider (int_div_seq).
// Build option INT_DIV_RADIX4_EN is consumed by int_div_seq, not here.
package int_div_pkg;

    localparam int MAX_W = 32;
    localparam int IDX_W = $clog2(MAX_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Helpers work on a MAX_W container; w selects the live width, upper bits return zero.
    function automatic logic [MAX_W-1:0] width_mask(input int w);
        return {MAX_W{1'b1}} >> (MAX_W - w);
    endfunction

    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                  input logic             neg,
                                                  input int               w);
        logic [MAX_W-1:0] r;
        r = neg ? ((~v) + MAX_W'(1)) : v;
        return r & width_mask(w);
    endfunction

    // Magnitude of a w-bit two's-complement value; the most negative value maps to 2^(w-1).
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v,
                                                 input int               w);
        return cond_neg(v, v[IDX_W'(w - 1)], w);
    endfunction

endpackage

// File: rtl/int_div_step.sv
// One restoring division step: shift in a dividend bit, subtract the divisor if it fits.
module int_div_step #(
    parameter int W = 5
) (
    input  logic [W:0]   rem_in,
    input  logic         bit_in,
    input  logic [W-1:0] dmag,
    output logic [W:0]   rem_out,
    output logic         q_bit
);

    logic [W+1:0] shifted;
    logic [W+1:0] diff;

    always_comb begin
        shifted = {rem_in, bit_in};
        diff    = shifted - {2'b00, dmag};
        q_bit   = (shifted >= {2'b00, dmag});
        // The partial remainder stays below dmag, so the result always fits W+1 bits.
        rem_out = (W+1)'(q_bit ? diff : shifted);
    end

endmodule

// File: rtl/int_div_seq.sv
// Multi-cycle signed divider (restoring, truncating toward zero) with valid/ready on both sides.
// Define INT_DIV_RADIX4_EN to retire two quotient bits per CALC cycle.
module int_div_seq
    import int_div_pkg::*;
#(
    parameter int W_IN_A = 13,
    parameter int W_IN_B = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W_IN_A-1:0] in_a,
    input  logic [W_IN_B-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W_IN_A-1:0] out_q,
    output logic [W_IN_B-1:0] out_r,
    output logic              out_dbz,
    output logic              out_ovf
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // a source holds its payload stable from raising valid until that edge.

`ifdef INT_DIV_RADIX4_EN
    localparam int STEPS = 2;
`else
    localparam int STEPS = 1;
`endif
    localparam int WP       = ((W_IN_A + STEPS - 1) / STEPS) * STEPS;
    localparam int ITERS    = WP / STEPS;
    localparam int CNT_W    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(ITERS - 1);
    localparam logic [W_IN_A-1:0] A_MIN    = {1'b1, {(W_IN_A-1){1'b0}}};

    state_t state, state_nxt;

    logic [W_IN_B:0]   rem, rem_nxt;
    logic [WP-1:0]     dvd, dvd_nxt;
    logic [WP-1:0]     quo, quo_nxt;
    logic [W_IN_B-1:0] dmag;
    logic [CNT_W-1:0]  cnt;
    logic              q_neg, r_neg, ovf_pend;
    logic              b_zero, last_step;
    logic [MAX_W-1:0]  a_abs_w, b_abs_w, q_fix_w, r_fix_w;

`ifdef INT_DIV_RADIX4_EN
    logic [W_IN_B:0] rem_mid;
    logic            qb_hi, qb_lo;

    int_div_step #(.W(W_IN_B)) u_step_hi (
        .rem_in  (rem),
        .bit_in  (dvd[WP-1]),
        .dmag    (dmag),
        .rem_out (rem_mid),
        .q_bit   (qb_hi)
    );

    int_div_step #(.W(W_IN_B)) u_step_lo (
        .rem_in  (rem_mid),
        .bit_in  (dvd[WP-2]),
        .dmag    (dmag),
        .rem_out (rem_nxt),
        .q_bit   (qb_lo)
    );

    assign dvd_nxt = WP'({dvd, 2'b00});
    assign quo_nxt = WP'({quo, qb_hi, qb_lo});
`else
    logic qb;

    int_div_step #(.W(W_IN_B)) u_step (
        .rem_in  (rem),
        .bit_in  (dvd[WP-1]),
        .dmag    (dmag),
        .rem_out (rem_nxt),
        .q_bit   (qb)
    );

    assign dvd_nxt = WP'({dvd, 1'b0});
    assign quo_nxt = WP'({quo, qb});
`endif

    always_comb begin
        a_abs_w   = abs_val(MAX_W'(in_a), W_IN_A);
        b_abs_w   = abs_val(MAX_W'(in_b), W_IN_B);
        q_fix_w   = cond_neg(MAX_W'(W_IN_A'(quo_nxt)), q_neg, W_IN_A);
        r_fix_w   = cond_neg(MAX_W'(W_IN_B'(rem_nxt)), r_neg, W_IN_B);
        b_zero    = (in_b == '0);
        last_step = (cnt == '0);
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid)  state_nxt = b_zero ? DONE : CALC;
            CALC: if (last_step) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dvd      <= '0;
            quo      <= '0;
            dmag     <= '0;
            cnt      <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            ovf_pend <= 1'b0;
            out_q    <= '0;
            out_r    <= '0;
            out_dbz  <= 1'b0;
            out_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem      <= '0;
                        dvd      <= WP'(W_IN_A'(a_abs_w));
                        quo      <= '0;
                        dmag     <= W_IN_B'(b_abs_w);
                        cnt      <= CNT_INIT;
                        q_neg    <= in_a[W_IN_A-1] ^ in_b[W_IN_B-1];
                        r_neg    <= in_a[W_IN_A-1];
                        ovf_pend <= (in_a == A_MIN) && (in_b == '1);
                        if (b_zero) begin
                            out_q   <= '1;
                            out_r   <= '0;
                            out_dbz <= 1'b1;
                            out_ovf <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    dvd <= dvd_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt - CNT_W'(1);
                    if (last_step) begin
                        // |MIN / -1| = 2^(W_IN_A-1) wraps back to MIN in W_IN_A bits.
                        out_q   <= W_IN_A'(q_fix_w);
                        out_r   <= W_IN_B'(r_fix_w);
                        out_dbz <= 1'b0;
                        out_ovf <= ovf_pend;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_div_seq.sv
// Self-checking bench for int_div_seq: directed corners, backpressure, mid-op reset, random ops.
module tb_int_div_seq;

    localparam int WA  = 13;
    localparam int WB  = 5;
    localparam int TMO = 200;
`ifdef INT_DIV_RADIX4_EN
    localparam int LAT = (WA + 1) / 2 + 1;
`else
    localparam int LAT = WA + 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WA-1:0] in_a = '0;
    logic [WB-1:0] in_b = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [WA-1:0] out_q;
    logic [WB-1:0] out_r;
    logic          out_dbz;
    logic          out_ovf;

    int n_checks = 0;
    int n_pass   = 0;
    logic [WA+WB+1:0] exp_q[$];

    int_div_seq #(.W_IN_A(WA), .W_IN_B(WB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_dbz   (out_dbz),
        .out_ovf   (out_ovf)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    // reference model: plain signed integer arithmetic, packed {q, r, dbz, ovf}
    function automatic logic [WA+WB+1:0] ref_div(input int a, input int b);
        logic [WA-1:0] q;
        logic [WB-1:0] r;
        logic dbz, ovf;
        int qi, ri;
        if (b == 0) begin
            q = '1; r = '0; dbz = 1'b1; ovf = 1'b0;
        end else begin
            qi  = a / b;
            ri  = a % b;
            q   = qi[WA-1:0];
            r   = ri[WB-1:0];
            dbz = 1'b0;
            ovf = (qi > (1 << (WA - 1)) - 1);
        end
        return {q, r, dbz, ovf};
    endfunction

    // driver tasks
    task automatic present_and_accept(input int a, input int b, output bit ok);
        int w;
        @(negedge clk);
        in_a = WA'(a);
        in_b = WB'(b);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < TMO) begin
            @(negedge clk);
            w++;
        end
        ok = in_ready;
        if (!ok) begin
            n_checks++;
            $display("FAIL accept_timeout in_ready=%0b required=1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic wait_result(output int lat, output bit ok);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < TMO) begin
            @(negedge clk);
            lat++;
        end
        ok = out_valid;
        if (!ok) begin
            n_checks++;
            $display("FAIL result_timeout out_valid=%0b required=1 after %0d edges", out_valid, lat);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    // scenarios
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else n_pass++;
        n_checks++; if (out_q !== '0) $display("FAIL reset_out_q got=%0h exp=0", out_q); else n_pass++;
        n_checks++; if (out_r !== '0) $display("FAIL reset_out_r got=%0h exp=0", out_r); else n_pass++;
        n_checks++; if (out_dbz !== 1'b0) $display("FAIL reset_out_dbz got=%0b exp=0", out_dbz); else n_pass++;
        n_checks++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf got=%0b exp=0", out_ovf); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int da[8] = '{100, -100, 100, -100, 4095, -4096, -4096, 5};
        int db[8] = '{7, 7, -7, -7, -16, -16, -1, 0};
        logic [WA+WB+1:0] e;
        int lat, exp_lat;
        bit ok;
        for (int i = 0; i < 8; i++) begin
            e = ref_div(da[i], db[i]);
            exp_lat = e[1] ? 1 : LAT;
            present_and_accept(da[i], db[i], ok);
            if (ok) begin
                wait_result(lat, ok);
                if (ok) begin
                    n_checks++; if (out_q !== e[WA+WB+1 -: WA]) $display("FAIL directed_q a=%0d b=%0d got=%0h exp=%0h", da[i], db[i], out_q, e[WA+WB+1 -: WA]); else n_pass++;
                    n_checks++; if (out_r !== e[WB+1 -: WB]) $display("FAIL directed_r a=%0d b=%0d got=%0h exp=%0h", da[i], db[i], out_r, e[WB+1 -: WB]); else n_pass++;
                    n_checks++; if (out_dbz !== e[1]) $display("FAIL directed_dbz a=%0d b=%0d got=%0b exp=%0b", da[i], db[i], out_dbz, e[1]); else n_pass++;
                    n_checks++; if (out_ovf !== e[0]) $display("FAIL directed_ovf a=%0d b=%0d got=%0b exp=%0b", da[i], db[i], out_ovf, e[0]); else n_pass++;
                    n_checks++; if (lat !== exp_lat) $display("FAIL directed_latency a=%0d b=%0d got=%0d exp=%0d", da[i], db[i], lat, exp_lat); else n_pass++;
                    release_result();
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [WA+WB+1:0] e, e2;
        int lat;
        bit ok;
        e  = ref_div(37, -5);
        e2 = ref_div(-50, 3);
        present_and_accept(37, -5, ok);
        if (!ok) return;
        wait_result(lat, ok);
        if (!ok) return;
        // next operands offered while the result is stalled; they must wait
        in_a = WA'(-50);
        in_b = WB'(3);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid cycle=%0d got=%0b exp=1", c, out_valid); else n_pass++;
            n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready cycle=%0d got=%0b exp=0", c, in_ready); else n_pass++;
            n_checks++; if ({out_q, out_r, out_dbz, out_ovf} !== e) $display("FAIL bp_hold cycle=%0d got=%0h exp=%0h", c, {out_q, out_r, out_dbz, out_ovf}, e); else n_pass++;
            @(negedge clk);
        end
        release_result();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got=%0b exp=0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%0b exp=1", in_ready); else n_pass++;
        @(posedge clk);
        wait_result(lat, ok);
        if (!ok) return;
        n_checks++; if ({out_q, out_r, out_dbz, out_ovf} !== e2) $display("FAIL bp_next_result got=%0h exp=%0h", {out_q, out_r, out_dbz, out_ovf}, e2); else n_pass++;
        n_checks++; if (lat !== LAT) $display("FAIL bp_next_latency got=%0d exp=%0d", lat, LAT); else n_pass++;
        release_result();
    endtask

    task automatic test_reset_mid_calc();
        logic [WA+WB+1:0] e;
        int lat;
        bit ok;
        present_and_accept(1234, 3, ok);
        if (!ok) return;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready got=%0b exp=1", in_ready); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); else n_pass++;
        n_checks++; if (out_q !== '0) $display("FAIL midrst_out_q got=%0h exp=0", out_q); else n_pass++;
        n_checks++; if (out_r !== '0) $display("FAIL midrst_out_r got=%0h exp=0", out_r); else n_pass++;
        n_checks++; if ({out_dbz, out_ovf} !== 2'b00) $display("FAIL midrst_flags got=%0b exp=0", {out_dbz, out_ovf}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        e = ref_div(60, -9);
        present_and_accept(60, -9, ok);
        if (!ok) return;
        wait_result(lat, ok);
        if (!ok) return;
        n_checks++; if (out_q !== e[WA+WB+1 -: WA]) $display("FAIL postrst_q got=%0h exp=%0h", out_q, e[WA+WB+1 -: WA]); else n_pass++;
        n_checks++; if (out_r !== e[WB+1 -: WB]) $display("FAIL postrst_r got=%0h exp=%0h", out_r, e[WB+1 -: WB]); else n_pass++;
        n_checks++; if (lat !== LAT) $display("FAIL postrst_latency got=%0d exp=%0d", lat, LAT); else n_pass++;
        release_result();
    endtask

    task automatic test_random();
        logic signed [WA-1:0] ra;
        logic signed [WB-1:0] rb;
        logic [WA+WB+1:0] e;
        int a, b, lat;
        bit ok;
        for (int i = 0; i < 1000; i++) begin
            ra = WA'($urandom);
            do rb = WB'($urandom); while (rb == 0);
            a = int'(ra);
            b = int'(rb);
            exp_q.push_back(ref_div(a, b));
            present_and_accept(a, b, ok);
            if (!ok) return;
            wait_result(lat, ok);
            if (!ok) return;
            e = exp_q.pop_front();
            n_checks++; if ({out_q, out_r, out_dbz, out_ovf} !== e) $display("FAIL random_result a=%0d b=%0d got=%0h exp=%0h", a, b, {out_q, out_r, out_dbz, out_ovf}, e); else n_pass++;
            n_checks++; if (lat !== LAT) $display("FAIL random_latency a=%0d b=%0d got=%0d exp=%0d", a, b, lat, LAT); else n_pass++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_calc();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
